// File: rtl/float_mul_seq.sv
// rtl/float_mul_seq.sv - sequential IEEE-754 single-precision multiplier
//
// Purpose: multiplies two IEEE single operands using a shift-add mantissa
// multiplier that handles one partial product per cycle. Zero, denormal,
// infinity and NaN operands are classified at accept and take a one-cycle
// bypass. Denormal inputs are flushed to zero, and no denormal results are
// produced.
//
// Optional feature: define FLOAT_MUL_ROUND_EN for round-to-nearest-even.
// When it is undefined, the mantissa is truncated.
//
// Ports:
//   clk_i    in   1   system clock
//   rst_i    in   1   synchronous active-high reset
//   a_i      in   32  operand A
//   b_i      in   32  operand B
//   valid_i  in   1   operands valid
//   ready_o  out  1   block can accept operands (IDLE only)
//   res_o    out  32  product
//   valid_o  out  1   res_o valid (DONE only)
//   ready_i  in   1   consumer accepts res_o

`timescale 1ns/1ps

module float_mul_seq #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] res_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int WORD_W = 1 + EXP_W + MANT_W;
   localparam int SIG_W  = MANT_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int EW     = EXP_W + 2;
   localparam int CNT_W  = $clog2(SIG_W);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SIG_W - 1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic [WORD_W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [PROD_W-1:0]    r_acc;
   logic [PROD_W-1:0]    r_mcand;
   logic [SIG_W-1:0]     r_mplier;
   logic                 r_sign;
   logic [EXP_W-1:0]     r_ea, r_eb;
   logic                 r_special;
   logic [WORD_W-1:0]    r_spec_res;
   logic [WORD_W-1:0]    r_res;

   // operand classification, evaluated on the live inputs at accept
   logic [EXP_W-1:0]  w_a_exp, w_b_exp;
   logic [MANT_W-1:0] w_a_frac, w_b_frac;
   logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic w_sign, w_special, w_accept;
   logic [WORD_W-1:0] w_spec_res;

   assign w_a_exp  = a_i[WORD_W-2 -: EXP_W];
   assign w_b_exp  = b_i[WORD_W-2 -: EXP_W];
   assign w_a_frac = a_i[MANT_W-1:0];
   assign w_b_frac = b_i[MANT_W-1:0];
   assign w_sign   = a_i[WORD_W-1] ^ b_i[WORD_W-1];
   // exponent field 0 covers denormals too: they are flushed to zero
   assign w_a_zero = (w_a_exp == '0);
   assign w_b_zero = (w_b_exp == '0);
   assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
   assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
   assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
   assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
   assign w_special = w_a_zero | w_b_zero | (&w_a_exp) | (&w_b_exp);
   assign w_accept  = valid_i && (r_state == S_IDLE);

   always_comb begin
      w_spec_res = {w_sign, {(WORD_W-1){1'b0}}};
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
         w_spec_res = QNAN;
      else if (w_a_inf || w_b_inf)
         w_spec_res = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
   end

   // normalisation of the finished 48-bit product
   logic                 w_top;
   logic [MANT_W-1:0]    w_mant_t, w_mant_f;
   logic signed [EW-1:0] w_exp_sum, w_exp_n, w_exp_f;
   logic [WORD_W-1:0]    w_norm_res;

   assign w_top     = r_acc[PROD_W-1];
   assign w_exp_sum = EW'({2'b00, r_ea}) + EW'({2'b00, r_eb}) - EW'(BIAS);
   assign w_exp_n   = w_exp_sum + EW'(w_top);
   assign w_mant_t  = w_top ? r_acc[PROD_W-2 -: MANT_W] : r_acc[PROD_W-3 -: MANT_W];

`ifdef FLOAT_MUL_ROUND_EN
   logic            w_guard, w_sticky, w_inc;
   logic [MANT_W:0] w_mant_r;
   assign w_guard  = w_top ? r_acc[MANT_W] : r_acc[MANT_W-1];
   assign w_sticky = w_top ? (|r_acc[MANT_W-1:0]) : (|r_acc[MANT_W-2:0]);
   assign w_inc    = w_guard && (w_sticky || w_mant_t[0]);
   assign w_mant_r = {1'b0, w_mant_t} + (MANT_W+1)'(w_inc);
   // a carry out leaves the low bits at zero, i.e. significand 1.0 * 2^(e+1)
   assign w_mant_f = w_mant_r[MANT_W-1:0];
   assign w_exp_f  = w_exp_n + EW'(w_mant_r[MANT_W]);
`else
   assign w_mant_f = w_mant_t;
   assign w_exp_f  = w_exp_n;
`endif

   always_comb begin
      w_norm_res = {r_sign, w_exp_f[EXP_W-1:0], w_mant_f};
      if (w_exp_f >= EXP_MAX)
         w_norm_res = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else if (w_exp_f <= EXP_ZERO)
         w_norm_res = {r_sign, {(WORD_W-1){1'b0}}};
   end

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_special ? S_NORM : S_MUL;
         S_MUL:  if (r_cnt == CNT_LAST) w_next = S_NORM;
         S_NORM: w_next = S_DONE;
         S_DONE: if (ready_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready_o = (r_state == S_IDLE);
      valid_o = (r_state == S_DONE);
   end

   assign res_o = r_res;

   // datapath
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_sign     <= 1'b0;
         r_ea       <= '0;
         r_eb       <= '0;
         r_special  <= 1'b0;
         r_spec_res <= '0;
         r_res      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_sign     <= w_sign;
               r_ea       <= w_a_exp;
               r_eb       <= w_b_exp;
               r_mcand    <= {{SIG_W{1'b0}}, 1'b1, w_a_frac};
               r_mplier   <= {1'b1, w_b_frac};
               r_acc      <= '0;
               r_cnt      <= '0;
               r_special  <= w_special;
               r_spec_res <= w_spec_res;
            end
            S_MUL: begin
               // multiplier is shifted right so bit 0 is always multiplier bit[cnt]
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_NORM: r_res <= r_special ? r_spec_res : w_norm_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_mul_seq.sv
// tb/tb_float_mul_seq.sv - self-checking bench for float_mul_seq
`timescale 1ns/1ps

module tb_float_mul_seq;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] a_i = '0, b_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] res_o;
   logic        valid_o;
   logic        ready_i = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   float_mul_seq dut (
      .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
      .ready_o(ready_o), .res_o(res_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // reference model straight from the arithmetic rules of IEEE single multiply
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output int lat);
      logic s;
      int ea, eb, e, sh;
      longint unsigned fa, fb, pm, kept, rem;
      bit az, bz, ai, bi, an, bn;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      fa = longint'(a[22:0]); fb = longint'(b[22:0]);
      az = (ea == 0); bz = (eb == 0);
      ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
      an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
      lat = 1;
      if (an || bn || (ai && bz) || (bi && az)) begin r = 32'h7FC00000; return; end
      if (ai || bi) begin r = {s, 8'hFF, 23'h0}; return; end
      if (az || bz) begin r = {s, 31'h0}; return; end
      lat = 25;
      pm = (fa + (64'd1 << 23)) * (fb + (64'd1 << 23));
      e  = ea + eb - 127;
      if (pm >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      kept = pm >> sh;
      rem  = pm - (kept << sh);
`ifdef FLOAT_MUL_ROUND_EN
      if (rem > (64'd1 << (sh - 1)) || (rem == (64'd1 << (sh - 1)) && kept[0])) kept++;
      if (kept == (64'd1 << 24)) begin kept = kept >> 1; e++; end
`else
      if (rem != 0) kept = kept;
`endif
      if (e >= 255)     r = {s, 8'hFF, 23'h0};
      else if (e <= 0)  r = {s, 31'h0};
      else              r = {s, e[7:0], kept[22:0]};
   endfunction

   // launches one operation and waits for valid_o; inputs are scrambled while busy
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok);
      int w = 0;
      while (!ready_o && w < 100) begin @(negedge clk); w++; end
      a_i = a; b_i = b; valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_i = $urandom; b_i = $urandom; valid_i = 1'b0;
      lat = 0; busy_ok = 1'b1;
      while (!valid_o && lat < 60) begin
         if (ready_o) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
         a_i = $urandom; b_i = $urandom;
         valid_i = valid_o ? 1'b0 : 1'($urandom);
      end
      valid_i = 1'b0;
      res = res_o;
   endtask

   task automatic complete(input string name);
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_after_hs"}, {30'h0, valid_o, ready_o}, 32'h1);
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] r, exp_r;
      int          lat, exp_lat;
      logic        bok;

      vecs.push_back('{"mul_2x3",      32'h40000000, 32'h40400000, 32'h40C00000, 25});
      vecs.push_back('{"mul_n1x05",    32'hBF800000, 32'h3F000000, 32'hBF000000, 25});
      vecs.push_back('{"zero_x_max",   32'h00000000, 32'h7F7FFFFF, 32'h00000000, 1});
      vecs.push_back('{"inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 1});
      vecs.push_back('{"ninf_x_2",     32'hFF800000, 32'h40000000, 32'hFF800000, 1});
      vecs.push_back('{"overflow",     32'h7F000000, 32'h7F000000, 32'h7F800000, 25});
      vecs.push_back('{"underflow",    32'h00800000, 32'h00800000, 32'h00000000, 25});
`ifdef FLOAT_MUL_ROUND_EN
      vecs.push_back('{"round_tie",    32'h3FC00000, 32'h3F800001, 32'h3FC00002, 25});
`else
      vecs.push_back('{"round_tie",    32'h3FC00000, 32'h3F800001, 32'h3FC00001, 25});
`endif
      vecs.push_back('{"mul_15x15",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 25});
      vecs.push_back('{"nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1});
      vecs.push_back('{"denorm_flush", 32'h80000001, 32'h3F800000, 32'h80000000, 1});
      vecs.push_back('{"inf_x_denorm", 32'h7F800000, 32'h00000005, 32'h7FC00000, 1});

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      check("reset_state", {res_o[29:0], valid_o, ready_o}, 32'h1);
      check("reset_res", res_o, 32'h0);

      // directed table
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, r, lat, bok);
         check({vecs[i].name, "_res"}, r, vecs[i].res);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
         check({vecs[i].name, "_busy"}, {31'h0, bok}, 32'h1);
         complete(vecs[i].name);
      end

      // backpressure: result held for 10 cycles while ready_i is low
      ready_i = 1'b0;
      do_op(32'hBF800000, 32'h3F000000, r, lat, bok);
      check("bp_res", r, 32'hBF000000);
      check("bp_lat", 32'(lat), 32'd25);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_res", res_o, 32'hBF000000);
         check("bp_hold_flags", {30'h0, valid_o, ready_o}, 32'h2);
      end
      complete("bp");
      begin
         int extra = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid_o) extra++;
         end
         check("bp_single_hs", 32'(extra), 32'd0);
      end

      // reset during MUL cycle 10 abandons the operation
      a_i = 32'h3FC00000; b_i = 32'h3FC00000; valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      check("midrst_flags", {30'h0, valid_o, ready_o}, 32'h1);
      check("midrst_res", res_o, 32'h0);
      begin
         int seen = 0;
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid_o) seen++;
         end
         check("midrst_no_result", 32'(seen), 32'd0);
      end
      do_op(32'hBFC00000 ^ 32'h80000000, 32'h3FC00000, r, lat, bok);
      check("post_rst_res", r, 32'h40100000);
      check("post_rst_lat", 32'(lat), 32'd25);
      complete("post_rst");

      // randomized against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom; rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         if ($urandom_range(0, 7) == 0) rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         if ($urandom_range(0, 15) == 0) rb[22:0] = 23'h0;
         ref_mul(ra, rb, exp_r, exp_lat);
         do_op(ra, rb, r, lat, bok);
         check("rand_res", r, exp_r);
         check("rand_lat", 32'(lat), 32'(exp_lat));
         complete("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
